sc_lineclear_controller: RTL and testbench
==========================================

Name: sc_lineclear_controller

Overview:
- Sequences the line-clear pass over the 8x8 background register bank of the game board after a piece lands.
- Scans rows bottom (7) to top (0) through the bank's row read port and detects full rows (8'hFF).
- For each full row it commands the bank to shift every row above it down by one.
- Reports lines cleared per pass and keeps a saturating running score for the game FSM and display.

Parameters:
- DATAWIDTH_BUS, 8, row width in cells; a full row is all ones.
- ROWADDR_WIDTH, 3, row address width; rows are numbered 0 (top) to 7 (bottom).
- COUNT_WIDTH, 4, width of the per-pass lines-cleared counter.
- SCORE_WIDTH, 8, width of the accumulated score.

Ports:
- SC_LINECLEAR_CLOCK_50  input  1  system clock
- SC_LINECLEAR_RESET_InLow  input  1  asynchronous active-low reset
- SC_LINECLEAR_Start_InLow  input  1  pass request from game FSM, active low, sampled in IDLE
- SC_LINECLEAR_ScoreClear_InLow  input  1  synchronous score clear, active low
- SC_LINECLEAR_RowData_InBUS  input  8  background row at RowAddr, combinational, valid the same cycle
- SC_LINECLEAR_RowAddr_OutBUS  output  3  row address presented to the bank
- SC_LINECLEAR_ShiftDown_OutLow  output  1  one-cycle active-low shift command
- SC_LINECLEAR_ShiftRow_OutBUS  output  3  row removed by ShiftDown
- SC_LINECLEAR_Busy_OutLow  output  1  low while a pass is in progress
- SC_LINECLEAR_Done_OutLow  output  1  one-cycle active-low pass-complete pulse
- SC_LINECLEAR_LinesCleared_OutBUS  output  4  lines removed in the current/last pass
- SC_LINECLEAR_Score_OutBUS  output  8  accumulated score

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; RowAddr 3'd7; ShiftRow 3'd0; ShiftDown, Busy and Done high (inactive); LinesCleared 0; Score 0.
- Reset asserted mid-pass aborts it at once. No further ShiftDown is issued, and a shift already pulsed is not undone.
- FSM states: IDLE, SCAN, SHIFT, WAIT, DONE. Busy is low in every state except IDLE.
- IDLE: RowAddr holds 7. If Start is low at a clock edge: go to SCAN, set RowAddr 7, clear LinesCleared.
- Start is level-sensitive. If it is still low when IDLE is re-entered, a new pass starts.
- SCAN: examine RowData.
  - RowData == 8'hFF: latch ShiftRow = RowAddr, go to SHIFT.
  - Otherwise, if RowAddr == 0: go to DONE.
  - Otherwise: decrement RowAddr and stay in SCAN.
- SHIFT: ShiftDown low for exactly this cycle. LinesCleared increments by 1. Go to WAIT.
- Bank contract for ShiftDown: on that edge the bank copies row r-1 to row r for r = ShiftRow down to 1, and loads row 0 with 0.
- WAIT: one cycle for the bank update to settle; RowAddr unchanged. Return to SCAN and rescan the same row, since the row above has dropped into it.
- DONE: Done low for this cycle only. Score <= min(Score + LinesCleared, 255), no wraparound. Go to IDLE.
- ScoreClear low on any edge sets Score to 0. If it coincides with the DONE update, the clear wins.
- Bounds: at most 8 shifts per pass. Row 0 is refilled with zeros after a shift, so the pass always terminates. LinesCleared maximum is 8.
- LinesCleared holds its value after DONE until the next pass starts.
- Latency, measured from the edge that samples Start:
  - A pass with no full rows has SCAN on cycles 1–8 and Done low on cycle 9.
  - Each full row adds 3 cycles (SHIFT, WAIT, rescan).
- All outputs are decoded from registered state and counters. No combinational path from RowData to ShiftDown or Done.

Test Plan:
- Reset: hold RESET_InLow low -> Busy=1, Done=1, ShiftDown=1, RowAddr=7, LinesCleared=0, Score=0. Assert reset again mid-SCAN -> IDLE immediately, without waiting for a clock edge.
- Empty board (all rows 8'h00), Start pulsed low one cycle -> RowAddr steps 7..0, no ShiftDown, Done low exactly on cycle 9, LinesCleared=0, Score=0.
- Only row 7 = 8'hFF (bank model applies shifts) -> one ShiftDown with ShiftRow=7, Done on cycle 12, LinesCleared=1, Score=1.
- Rows 7 and 5 = 8'hFF, row 6 = 8'h0F -> first ShiftDown ShiftRow=7. After the drop, row 6 now holds the former full row 5, so the second ShiftDown has ShiftRow=6. Final rows 7=8'h0F, 6..0=8'h00; LinesCleared=2.
- Score saturation: drive passes until Score=254, then run a pass clearing 4 lines (rows 4–7 full) -> Score=255. Next pass with 1 line -> Score stays 255.
- ScoreClear low on the same cycle Done is low, with LinesCleared=3 -> Score=0 afterwards. Reset asserted during SHIFT -> ShiftDown high the same cycle, Busy=1, state IDLE.

Source files
------------

// File: rtl/sc_lineclear_controller.sv
// Line-clear sequencer for the 8x8 background bank: scans rows bottom-up,
// commands a shift-down for each full row, and accumulates a saturating score.
module sc_lineclear_controller #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int ROWADDR_WIDTH = 3,
   parameter int COUNT_WIDTH   = 4,
   parameter int SCORE_WIDTH   = 8
) (
   input  logic                     SC_LINECLEAR_CLOCK_50,
   input  logic                     SC_LINECLEAR_RESET_InLow,
   input  logic                     SC_LINECLEAR_Start_InLow,
   input  logic                     SC_LINECLEAR_ScoreClear_InLow,
   input  logic [DATAWIDTH_BUS-1:0] SC_LINECLEAR_RowData_InBUS,
   output logic [ROWADDR_WIDTH-1:0] SC_LINECLEAR_RowAddr_OutBUS,
   output logic                     SC_LINECLEAR_ShiftDown_OutLow,
   output logic [ROWADDR_WIDTH-1:0] SC_LINECLEAR_ShiftRow_OutBUS,
   output logic                     SC_LINECLEAR_Busy_OutLow,
   output logic                     SC_LINECLEAR_Done_OutLow,
   output logic [COUNT_WIDTH-1:0]   SC_LINECLEAR_LinesCleared_OutBUS,
   output logic [SCORE_WIDTH-1:0]   SC_LINECLEAR_Score_OutBUS
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_SHIFT,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [ROWADDR_WIDTH-1:0] ROW_BOTTOM = '1;
   localparam logic [ROWADDR_WIDTH-1:0] ROW_TOP    = '0;

   state_t                   state_q, state_d;
   logic [ROWADDR_WIDTH-1:0] row_addr_q, row_addr_d;
   logic [ROWADDR_WIDTH-1:0] shift_row_q, shift_row_d;
   logic                     shift_n_q, shift_n_d;
   logic                     busy_n_q, busy_n_d;
   logic                     done_n_q, done_n_d;
   logic [COUNT_WIDTH-1:0]   lines_q, lines_d;
   logic [SCORE_WIDTH-1:0]   score_q, score_d;
   logic [SCORE_WIDTH:0]     score_sum;

   // One extra bit catches overflow so the score clamps instead of wrapping.
   assign score_sum = {1'b0, score_q} + (SCORE_WIDTH+1)'(lines_q);

   always_comb begin
      state_d     = state_q;
      row_addr_d  = row_addr_q;
      shift_row_d = shift_row_q;
      lines_d     = lines_q;
      score_d     = score_q;

      case (state_q)
         ST_IDLE: begin
            row_addr_d = ROW_BOTTOM;
            if (!SC_LINECLEAR_Start_InLow) begin
               state_d = ST_SCAN;
               lines_d = '0;
            end
         end
         ST_SCAN: begin
            if (SC_LINECLEAR_RowData_InBUS == '1) begin
               shift_row_d = row_addr_q;
               state_d     = ST_SHIFT;
            end else if (row_addr_q == ROW_TOP) begin
               state_d = ST_DONE;
            end else begin
               row_addr_d = row_addr_q - ROWADDR_WIDTH'(1);
            end
         end
         ST_SHIFT: begin
            lines_d = lines_q + COUNT_WIDTH'(1);
            state_d = ST_WAIT;
         end
         // Row address is held so the row that dropped in gets rescanned.
         ST_WAIT: state_d = ST_SCAN;
         ST_DONE: begin
            score_d    = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];
            row_addr_d = ROW_BOTTOM;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            row_addr_d = ROW_BOTTOM;
         end
      endcase

      if (!SC_LINECLEAR_ScoreClear_InLow) score_d = '0;

      // Strobes are decoded from the next state so they align with the state register.
      shift_n_d = (state_d != ST_SHIFT);
      done_n_d  = (state_d != ST_DONE);
      busy_n_d  = (state_d == ST_IDLE);
   end

   always_ff @(posedge SC_LINECLEAR_CLOCK_50 or negedge SC_LINECLEAR_RESET_InLow) begin
      if (!SC_LINECLEAR_RESET_InLow) begin
         state_q     <= ST_IDLE;
         row_addr_q  <= ROW_BOTTOM;
         shift_row_q <= '0;
         shift_n_q   <= 1'b1;
         busy_n_q    <= 1'b1;
         done_n_q    <= 1'b1;
         lines_q     <= '0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         row_addr_q  <= row_addr_d;
         shift_row_q <= shift_row_d;
         shift_n_q   <= shift_n_d;
         busy_n_q    <= busy_n_d;
         done_n_q    <= done_n_d;
         lines_q     <= lines_d;
         score_q     <= score_d;
      end
   end

   assign SC_LINECLEAR_RowAddr_OutBUS      = row_addr_q;
   assign SC_LINECLEAR_ShiftDown_OutLow    = shift_n_q;
   assign SC_LINECLEAR_ShiftRow_OutBUS     = shift_row_q;
   assign SC_LINECLEAR_Busy_OutLow         = busy_n_q;
   assign SC_LINECLEAR_Done_OutLow         = done_n_q;
   assign SC_LINECLEAR_LinesCleared_OutBUS = lines_q;
   assign SC_LINECLEAR_Score_OutBUS        = score_q;

endmodule

// File: tb/tb_sc_lineclear_controller.sv
// Bench for sc_lineclear_controller: a bank model applies shifts, a table of
// boards drives passes, and expected shift rows are scoreboarded in a queue.
module tb_sc_lineclear_controller;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_n = 1'b1;
   logic             sclr_n = 1'b1;
   logic [7:0]       row_data;
   logic [2:0]       row_addr;
   logic             shift_n;
   logic [2:0]       shift_row;
   logic             busy_n;
   logic             done_n;
   logic [3:0]       lines;
   logic [7:0]       score;

   logic [7:0][7:0]  board;
   logic [7:0][7:0]  board_init = '0;
   logic             load_req = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];
   int model_score = 0;

   always #5 clk = ~clk;

   sc_lineclear_controller dut (
      .SC_LINECLEAR_CLOCK_50           (clk),
      .SC_LINECLEAR_RESET_InLow        (rst_n),
      .SC_LINECLEAR_Start_InLow        (start_n),
      .SC_LINECLEAR_ScoreClear_InLow   (sclr_n),
      .SC_LINECLEAR_RowData_InBUS      (row_data),
      .SC_LINECLEAR_RowAddr_OutBUS     (row_addr),
      .SC_LINECLEAR_ShiftDown_OutLow   (shift_n),
      .SC_LINECLEAR_ShiftRow_OutBUS    (shift_row),
      .SC_LINECLEAR_Busy_OutLow        (busy_n),
      .SC_LINECLEAR_Done_OutLow        (done_n),
      .SC_LINECLEAR_LinesCleared_OutBUS(lines),
      .SC_LINECLEAR_Score_OutBUS       (score)
   );

   // Background bank: combinational read, shift-down on the ShiftDown edge.
   assign row_data = board[row_addr];
   always @(posedge clk) begin
      if (load_req) board <= board_init;
      else if (!shift_n) begin
         for (int k = 7; k >= 1; k--)
            if (k <= int'(shift_row)) board[k] <= board[k-1];
         board[0] <= 8'h00;
      end
   end

   typedef struct {
      logic [63:0] b;
      int          exp_lines;
      logic [63:0] exp_final;
   } vec_t;
   vec_t vt[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference line-clear: pushes the row index of every shift in order.
   function automatic void model_shifts(input logic [7:0][7:0] b_in);
      logic [7:0][7:0] b = b_in;
      int r = 7;
      while (1) begin
         if (b[r] == 8'hFF) begin
            exp_q.push_back(r);
            for (int k = 7; k >= 1; k--) if (k <= r) b[k] = b[k-1];
            b[0] = 8'h00;
         end else if (r == 0) break;
         else r--;
      end
   endfunction

   task automatic load(input logic [63:0] b);
      @(negedge clk);
      board_init = b;
      load_req   = 1'b1;
      @(negedge clk);
      load_req   = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_n = 1'b0;
      @(posedge clk);
      #1 start_n = 1'b1;
   endtask

   task automatic run_pass(input logic [63:0] b, input int exp_lines,
                           input logic [63:0] exp_final, input bit clr_at_done);
      int done_at = 0;
      load(b);
      model_shifts(b);
      if (clr_at_done) model_score = 0;
      else model_score = (model_score + exp_lines > 255) ? 255 : model_score + exp_lines;
      pulse_start();
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) chk("busy_in_pass", busy_n, 0);
         if (exp_lines == 0 && c <= 8) chk("scan_rowaddr", row_addr, 8 - c);
         if (!shift_n) begin
            if (exp_q.size() == 0) chk("unexpected_shift", 1, 0);
            else chk("shift_row", shift_row, exp_q.pop_front());
         end
         if (!done_n) begin
            done_at = c;
            if (clr_at_done) sclr_n = 1'b0;
            break;
         end
      end
      if (done_at == 0) chk("done_timeout", 0, 1);
      chk("done_cycle", done_at, 9 + 3 * exp_lines);
      @(posedge clk);
      #1 sclr_n = 1'b1;
      chk("lines", lines, exp_lines);
      chk("score", score, model_score);
      chk("done_release", done_n, 1);
      chk("busy_release", busy_n, 1);
      chk("board_final", board, exp_final);
      chk("shifts_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      vt[0] = '{64'h0000000000000000, 0, 64'h0};
      vt[1] = '{64'hFF00000000000000, 1, 64'h0};
      vt[2] = '{64'hFF0FFF0000000000, 2, 64'h0F00000000000000};
      vt[3] = '{64'hFFFFFFFF00000000, 4, 64'h0};
      vt[4] = '{64'hFFFFFFFFFFFFFFFF, 8, 64'h0};
      vt[5] = '{64'h00000000000000FF, 1, 64'h0};
      vt[6] = '{64'hFFAAFF5500000000, 2, 64'hAA55000000000000};

      #12;
      chk("rst_busy", busy_n, 1);
      chk("rst_done", done_n, 1);
      chk("rst_shift", shift_n, 1);
      chk("rst_rowaddr", row_addr, 7);
      chk("rst_shiftrow", shift_row, 0);
      chk("rst_lines", lines, 0);
      chk("rst_score", score, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_pass(vt[i].b, vt[i].exp_lines, vt[i].exp_final, 1'b0);

      // Walk the score to 254, then check saturation at 255.
      for (int i = 0; i < 29; i++) run_pass(vt[4].b, 8, 64'h0, 1'b0);
      run_pass(vt[3].b, 4, 64'h0, 1'b0);
      chk("score_254", score, 254);
      run_pass(vt[3].b, 4, 64'h0, 1'b0);
      chk("score_sat", score, 255);
      run_pass(vt[1].b, 1, 64'h0, 1'b0);
      chk("score_hold", score, 255);

      run_pass(64'hFFFFFF0000000000, 3, 64'h0, 1'b1);

      // Asynchronous reset in SCAN.
      load(64'h0);
      pulse_start();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_scan_busy", busy_n, 1);
      chk("rst_scan_rowaddr", row_addr, 7);
      @(negedge clk) rst_n = 1'b1;
      model_score = 0;

      // Asynchronous reset in SHIFT: the pending shift must not reach the bank.
      load(64'hFF00000000000000);
      pulse_start();
      begin
         int seen = 0;
         for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (!shift_n) seen = 1;
         end
         if (seen == 0) chk("shift_timeout", 0, 1);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_shift_sd", shift_n, 1);
      chk("rst_shift_busy", busy_n, 1);
      chk("rst_shift_done", done_n, 1);
      @(negedge clk) rst_n = 1'b1;
      chk("rst_shift_board", board, 64'hFF00000000000000);

      run_pass(64'hFF00000000000000, 1, 64'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
